// File: rtl/prog_mem_pkg.sv
// Shared constants for the program memory / boot sequencer.
package prog_mem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/prog_mem_if.sv
// Program load port: host streams words to the sequencer over valid/ready.
interface prog_mem_if;
    import prog_mem_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);

endinterface

// File: rtl/prog_ram.sv
// Program storage: one synchronous write port, one asynchronous read port.
module prog_ram
    import prog_mem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; a new program simply overwrites them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem.sv
// Program memory and boot sequencer feeding mproc's fetch port.
//
// state | meaning
// IDLE  | program (possibly empty) held, processor in reset, awaiting load or start
// LOAD  | receiving program words at the write pointer
// RUN   | processor released, run_cycles counting up to MAX_CYCLES
// DONE  | run ended, processor parked in reset, run_cycles frozen
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int MAX_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    prog_mem_if.slave         ld,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              proc_reset,
    output logic [CNT_W-1:0]  loaded_count,
    output logic [CNT_W-1:0]  run_cycles,
    output logic [1:0]        state,
    output logic              err
);

    localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic              err_q, err_d;

    logic              accept;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] ram_rd;

    assign ld.ld_ready = !reset && (state_q != ST_RUN);
    assign accept      = ld.ld_valid && ld.ld_ready;

    // Sequencer: loading takes priority over start; overflow ends the load with err set.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        run_d   = run_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = wptr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    we      = 1'b1;
                    waddr   = '0;
                    wptr_d  = ADDR_W'(1);
                    count_d = CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = ld.ld_last ? ST_IDLE : ST_LOAD;
                end else if (start && (count_q != '0)) begin
                    run_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we      = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (ld.ld_last) begin
                        state_d = ST_IDLE;
                    end else if (wptr_q == LAST_ADR) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                run_d = run_q + 1'b1;
                if (!start || (run_d == MAX_C)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; a reset discards any partial program.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            count_q <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    prog_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (ld.ld_data),
        .raddr (addr),
        .rdata (ram_rd)
    );

    assign rd_data      = ((state_q == ST_RUN) && ({1'b0, addr} < count_q)) ? ram_rd : '0;
    assign proc_reset   = reset || (state_q != ST_RUN);
    assign loaded_count = count_q;
    assign run_cycles   = run_q;
    assign state        = state_q;
    assign err          = err_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: load, run, overflow, collisions and reset.
module tb_prog_mem;
    import prog_mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data;
    logic              proc_reset;
    logic [7:0]        loaded_count;
    logic [7:0]        run_cycles;
    logic [1:0]        state;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    prog_mem_if ld_if ();

    prog_mem #(.MAX_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld           (ld_if),
        .start        (start),
        .addr         (addr),
        .rd_data      (rd_data),
        .proc_reset   (proc_reset),
        .loaded_count (loaded_count),
        .run_cycles   (run_cycles),
        .state        (state),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b1;
        ld_if.ld_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", state, ST_IDLE); end
        n_checks++; if (loaded_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", loaded_count); end
        n_checks++; if (run_cycles !== 8'd0) begin n_fail++; $display("FAIL reset_run got %0d exp 0", run_cycles); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL reset_proc got %b exp 1", proc_reset); end
        n_checks++; if (ld_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", ld_if.ld_ready); end
        reset = 1'b0;
        ld_if.ld_valid = 1'b0;
        #1;
        n_checks++; if (ld_if.ld_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b exp 1", ld_if.ld_ready); end
    endtask

    task automatic test_load3;
        logic [15:0] w [3];
        w = '{16'h1111, 16'h2222, 16'h3333};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_if.ld_valid = 1'b1;
            ld_if.ld_data  = w[i];
            ld_if.ld_last  = (i == 2);
            #1;
            n_checks++; if (ld_if.ld_ready !== 1'b1) begin n_fail++; $display("FAIL load3_ready word %0d got %b exp 1", i, ld_if.ld_ready); end
            @(posedge clk);
        end
        @(negedge clk);
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
        addr = 7'd1;
        #1;
        n_checks++; if (loaded_count !== 8'd3) begin n_fail++; $display("FAIL load3_count got %0d exp 3", loaded_count); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL load3_state got %0d exp %0d", state, ST_IDLE); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL load3_err got %b exp 0", err); end
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL load3_proc got %b exp 1", proc_reset); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL load3_idle_rd got %h exp 0000", rd_data); end
    endtask

    task automatic test_run_read;
        @(negedge clk);
        start = 1'b1;
        addr  = 7'd1;
        @(negedge clk);
        n_checks++; if (state !== ST_RUN) begin n_fail++; $display("FAIL run_state got %0d exp %0d", state, ST_RUN); end
        n_checks++; if (proc_reset !== 1'b0) begin n_fail++; $display("FAIL run_proc got %b exp 0", proc_reset); end
        n_checks++; if (run_cycles !== 8'd0) begin n_fail++; $display("FAIL run_cycles0 got %0d exp 0", run_cycles); end
        n_checks++; if (rd_data !== 16'h2222) begin n_fail++; $display("FAIL run_rd1 got %h exp 2222", rd_data); end
        addr = 7'd5; #1;
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL run_rd5 got %h exp 0000", rd_data); end
        addr = 7'd2; #1;
        n_checks++; if (rd_data !== 16'h3333) begin n_fail++; $display("FAIL run_rd2 got %h exp 3333", rd_data); end
        addr = 7'd0; #1;
        n_checks++; if (rd_data !== 16'h1111) begin n_fail++; $display("FAIL run_rd0 got %h exp 1111", rd_data); end
    endtask

    task automatic test_run_to_done;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_checks++; if (run_cycles !== 8'(i)) begin n_fail++; $display("FAIL count_run got %0d exp %0d", run_cycles, i); end
            n_checks++; if (state !== ((i == 10) ? ST_DONE : ST_RUN)) begin n_fail++; $display("FAIL count_state at %0d got %0d", i, state); end
        end
        start = 1'b0;
        addr  = 7'd1;
        #1;
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL done_proc got %b exp 1", proc_reset); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL done_rd got %h exp 0000", rd_data); end
        @(negedge clk);
        n_checks++; if (run_cycles !== 8'd10) begin n_fail++; $display("FAIL done_hold got %0d exp 10", run_cycles); end
        n_checks++; if (state !== ST_DONE) begin n_fail++; $display("FAIL done_state got %0d exp %0d", state, ST_DONE); end
        n_checks++; if (ld_if.ld_ready !== 1'b1) begin n_fail++; $display("FAIL done_ready got %b exp 1", ld_if.ld_ready); end
    endtask

    task automatic test_abort;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_checks++; if (state !== ST_RUN) begin n_fail++; $display("FAIL abort_run got %0d exp %0d", state, ST_RUN); end
        n_checks++; if (ld_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready got %b exp 0", ld_if.ld_ready); end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== ST_DONE) begin n_fail++; $display("FAIL abort_state got %0d exp %0d", state, ST_DONE); end
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL abort_proc got %b exp 1", proc_reset); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (i == 128) begin
                n_checks++; if (loaded_count !== 8'd128) begin n_fail++; $display("FAIL ovf_count got %0d exp 128", loaded_count); end
                n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", err); end
                n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL ovf_state got %0d exp %0d", state, ST_IDLE); end
            end
            if (i == 129) begin
                n_checks++; if (loaded_count !== 8'd1) begin n_fail++; $display("FAIL new_count got %0d exp 1", loaded_count); end
                n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL new_err got %b exp 0", err); end
                n_checks++; if (state !== ST_LOAD) begin n_fail++; $display("FAIL new_state got %0d exp %0d", state, ST_LOAD); end
            end
            ld_if.ld_valid = 1'b1;
            ld_if.ld_data  = 16'(16'h4000 + i);
            ld_if.ld_last  = 1'b0;
            #1;
            n_checks++; if (ld_if.ld_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready word %0d got %b exp 1", i, ld_if.ld_ready); end
            @(posedge clk);
        end
        @(negedge clk);
        ld_if.ld_data = 16'hABCD;
        ld_if.ld_last = 1'b1;
        @(negedge clk);
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
        n_checks++; if (loaded_count !== 8'd3) begin n_fail++; $display("FAIL ovf_reload_count got %0d exp 3", loaded_count); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL ovf_reload_state got %0d exp %0d", state, ST_IDLE); end
        start = 1'b1;
        @(negedge clk);
        addr = 7'd0; #1;
        n_checks++; if (rd_data !== 16'h4080) begin n_fail++; $display("FAIL ovf_rd0 got %h exp 4080", rd_data); end
        addr = 7'd2; #1;
        n_checks++; if (rd_data !== 16'hABCD) begin n_fail++; $display("FAIL ovf_rd2 got %h exp abcd", rd_data); end
        addr = 7'd3; #1;
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL ovf_rd3 got %h exp 0000", rd_data); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_start_collide;
        @(negedge clk);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 16'h5555;
        ld_if.ld_last  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        ld_if.ld_valid = 1'b0;
        n_checks++; if (state !== ST_LOAD) begin n_fail++; $display("FAIL coll_state got %0d exp %0d", state, ST_LOAD); end
        n_checks++; if (loaded_count !== 8'd1) begin n_fail++; $display("FAIL coll_count got %0d exp 1", loaded_count); end
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL coll_proc got %b exp 1", proc_reset); end
        @(negedge clk);
        n_checks++; if (state !== ST_LOAD) begin n_fail++; $display("FAIL coll_hold got %0d exp %0d", state, ST_LOAD); end
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 16'h6666;
        ld_if.ld_last  = 1'b1;
        @(negedge clk);
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
        start = 1'b0;
        n_checks++; if (loaded_count !== 8'd2) begin n_fail++; $display("FAIL coll_final got %0d exp 2", loaded_count); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL coll_idle got %0d exp %0d", state, ST_IDLE); end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        start = 1'b1;
        addr  = 7'd1;
        repeat (5) @(negedge clk);
        n_checks++; if (run_cycles !== 8'd4) begin n_fail++; $display("FAIL mid_run got %0d exp 4", run_cycles); end
        n_checks++; if (rd_data !== 16'h6666) begin n_fail++; $display("FAIL mid_rd got %h exp 6666", rd_data); end
        reset = 1'b1;
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 16'h7777;
        #1;
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL mid_proc got %b exp 1", proc_reset); end
        n_checks++; if (ld_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b exp 0", ld_if.ld_ready); end
        @(negedge clk);
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL mid_state got %0d exp %0d", state, ST_IDLE); end
        n_checks++; if (loaded_count !== 8'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", loaded_count); end
        n_checks++; if (run_cycles !== 8'd0) begin n_fail++; $display("FAIL mid_cycles got %0d exp 0", run_cycles); end
        n_checks++; if (ld_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready2 got %b exp 0", ld_if.ld_ready); end
        reset = 1'b0;
        ld_if.ld_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL empty_start got %0d exp %0d", state, ST_IDLE); end
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL empty_proc got %b exp 1", proc_reset); end
        start = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        addr           = '0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = '0;
        ld_if.ld_last  = 1'b0;
        test_reset();
        test_load3();
        test_run_read();
        test_run_to_done();
        test_abort();
        test_overflow();
        test_load_start_collide();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
